mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns one execute-stage instruction at a time into a
// single outstanding bus transaction and presents a registered writeback result.
module mem_access_unit #(
   parameter int          ADDR_W   = 32,
   parameter logic [4:0]  EXC_NONE = 5'd0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic [3:0]        ex_mem_op,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [31:0]       ex_store_data,
   input  logic              ex_reg_we,
   input  logic [4:0]        ex_reg_addr,
   input  logic [31:0]       ex_reg_data,
   input  logic [4:0]        ex_excep_code,
   input  logic [31:0]       ex_pc,
   output logic              is_busbusy,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [31:0]       mem_rdata,
   output logic              wb_valid,
   output logic              wb_reg_we,
   output logic [4:0]        wb_reg_addr,
   output logic [31:0]       wb_reg_data,
   output logic [4:0]        wb_excep_code,
   output logic [31:0]       wb_pc
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   // Operation bit positions within ex_mem_op = {lh, lw, sh, sw}.
   localparam int OP_LH = 3;
   localparam int OP_LW = 2;
   localparam int OP_SH = 1;
   localparam int OP_SW = 0;

   function automatic logic [31:0] half_sext(input logic [31:0] word, input logic hi_sel);
      logic [15:0] half;
      half = hi_sel ? word[31:16] : word[15:0];
      return {{16{half[15]}}, half};
   endfunction

   function automatic logic [3:0] half_strobe(input logic hi_sel);
      return hi_sel ? 4'b1100 : 4'b0011;
   endfunction

   state_t            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       sdata_q, sdata_d;
   logic [4:0]        rdst_q, rdst_d;
   logic [31:0]       pc_q, pc_d;

   logic              wb_valid_q, wb_valid_d;
   logic              wb_reg_we_q, wb_reg_we_d;
   logic [4:0]        wb_reg_addr_q, wb_reg_addr_d;
   logic [31:0]       wb_reg_data_q, wb_reg_data_d;
   logic [4:0]        wb_excep_code_q, wb_excep_code_d;
   logic [31:0]       wb_pc_q, wb_pc_d;

   logic              is_load_s;
   logic [31:0]       load_data_s;

   assign is_load_s   = op_q[OP_LH] | op_q[OP_LW];
   assign load_data_s = op_q[OP_LW] ? mem_rdata : half_sext(mem_rdata, addr_q[1]);

   // Next-state, transaction latch and writeback selection.
   always_comb begin
      state_d         = state_q;
      op_d            = op_q;
      addr_d          = addr_q;
      sdata_d         = sdata_q;
      rdst_d          = rdst_q;
      pc_d            = pc_q;
      wb_valid_d      = 1'b0;
      wb_reg_we_d     = wb_reg_we_q;
      wb_reg_addr_d   = wb_reg_addr_q;
      wb_reg_data_d   = wb_reg_data_q;
      wb_excep_code_d = wb_excep_code_q;
      wb_pc_d         = wb_pc_q;

      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               // Non-memory or excepting instructions pass straight through.
               if ((ex_mem_op == 4'b0000) || (ex_excep_code != EXC_NONE)) begin
                  wb_valid_d      = 1'b1;
                  wb_reg_we_d     = ex_reg_we & (ex_excep_code == EXC_NONE);
                  wb_reg_addr_d   = ex_reg_addr;
                  wb_reg_data_d   = ex_reg_data;
                  wb_excep_code_d = ex_excep_code;
                  wb_pc_d         = ex_pc;
                  state_d         = IDLE;
               end else begin
                  op_d    = ex_mem_op;
                  addr_d  = ex_addr;
                  sdata_d = ex_store_data;
                  rdst_d  = ex_reg_addr;
                  pc_d    = ex_pc;
                  state_d = REQ;
               end
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (mem_addr_ok) begin
               state_d = mem_data_ok ? IDLE : WAIT;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (mem_data_ok) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (((state_q == REQ) && mem_addr_ok && mem_data_ok) ||
          ((state_q == WAIT) && mem_data_ok)) begin
         wb_valid_d      = 1'b1;
         wb_reg_we_d     = is_load_s;
         wb_reg_addr_d   = rdst_q;
         wb_reg_data_d   = is_load_s ? load_data_s : 32'h0000_0000;
         wb_excep_code_d = EXC_NONE;
         wb_pc_d         = pc_q;
      end else begin
         wb_reg_we_d = wb_reg_we_d;
      end
   end

   // Bus request outputs, driven only from registered state and forced to zero otherwise.
   always_comb begin
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = 32'h0000_0000;
      mem_wstrb = 4'b0000;
      if (state_q == REQ) begin
         mem_req  = 1'b1;
         mem_wr   = op_q[OP_SH] | op_q[OP_SW];
         mem_addr = addr_q;
         if (op_q[OP_SW]) begin
            mem_wdata = sdata_q;
            mem_wstrb = 4'b1111;
         end else if (op_q[OP_SH]) begin
            mem_wdata = {2{sdata_q[15:0]}};
            mem_wstrb = half_strobe(addr_q[1]);
         end else begin
            mem_wstrb = 4'b0000;
         end
      end else begin
         mem_req = 1'b0;
      end
   end

   assign is_busbusy    = (state_q == REQ) | (state_q == WAIT);
   assign wb_valid      = wb_valid_q;
   assign wb_reg_we     = wb_reg_we_q;
   assign wb_reg_addr   = wb_reg_addr_q;
   assign wb_reg_data   = wb_reg_data_q;
   assign wb_excep_code = wb_excep_code_q;
   assign wb_pc         = wb_pc_q;

   // State, latch and writeback registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         op_q            <= 4'b0000;
         addr_q          <= {ADDR_W{1'b0}};
         sdata_q         <= 32'h0000_0000;
         rdst_q          <= 5'd0;
         pc_q            <= 32'h0000_0000;
         wb_valid_q      <= 1'b0;
         wb_reg_we_q     <= 1'b0;
         wb_reg_addr_q   <= 5'd0;
         wb_reg_data_q   <= 32'h0000_0000;
         wb_excep_code_q <= 5'd0;
         wb_pc_q         <= 32'h0000_0000;
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         addr_q          <= addr_d;
         sdata_q         <= sdata_d;
         rdst_q          <= rdst_d;
         pc_q            <= pc_d;
         wb_valid_q      <= wb_valid_d;
         wb_reg_we_q     <= wb_reg_we_d;
         wb_reg_addr_q   <= wb_reg_addr_d;
         wb_reg_data_q   <= wb_reg_data_d;
         wb_excep_code_q <= wb_excep_code_d;
         wb_pc_q         <= wb_pc_d;
      end
   end

endmodule
